// File: rtl/sprite_line_sequencer.sv
// Per-scanline sprite prep scheduler: swaps the ping-pong line buffers at SWAP_H,
// clears the back buffer, kicks the frontend and reports row readiness / overruns.
module sprite_line_sequencer #(
    parameter int H_TOTAL  = 1600,
    parameter int SWAP_H   = 1599,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525,
    parameter int LINE_W   = 640
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        sprite_en,
    input  logic        fe_done,
    input  logic        draw_busy,
    input  logic        draw_req,
    output logic        start_row,
    output logic [9:0]  next_vcount,
    output logic        disp_sel,
    output logic        clr_we,
    output logic [9:0]  clr_addr,
    output logic        row_ready,
    output logic        overrun,
    output logic [15:0] overrun_cnt
);

    if (SWAP_H >= H_TOTAL) begin : g_bad_swap
        $error("SWAP_H must be below H_TOTAL");
    end
    if (LINE_W > 1024) begin : g_bad_linew
        $error("LINE_W must not exceed 1024");
    end

    localparam logic [10:0] SWAP_AT = 11'(SWAP_H);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0]  A_LAST  = 10'(LINE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_START, S_GUARD, S_WAIT, S_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_start_row, r_disp_sel, r_clr_we, r_row_ready, r_overrun;
    logic [9:0]  r_next_vcount, r_clr_addr;
    logic [15:0] r_overrun_cnt;

    logic        w_swap, w_clr_last, w_drained;
    logic [9:0]  w_nv;
    logic        w_start_row_nxt, w_clr_we_nxt, w_row_ready_nxt, w_overrun_nxt;
    logic [9:0]  w_clr_addr_nxt;
    logic [15:0] w_overrun_cnt_nxt;

    assign w_swap     = (hcount == SWAP_AT);
    assign w_nv       = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
    assign w_clr_last = (r_clr_addr == A_LAST);
    assign w_drained  = fe_done && !draw_busy && !draw_req;

    // State register; the registered outputs ride along so every port is a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_start_row   <= 1'b0;
            r_next_vcount <= 10'd0;
            r_disp_sel    <= 1'b0;
            r_clr_we      <= 1'b0;
            r_clr_addr    <= 10'd0;
            r_row_ready   <= 1'b0;
            r_overrun     <= 1'b0;
            r_overrun_cnt <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_start_row   <= w_start_row_nxt;
            r_next_vcount <= w_swap ? w_nv : r_next_vcount;
            r_disp_sel    <= r_disp_sel ^ w_swap;
            r_clr_we      <= w_clr_we_nxt;
            r_clr_addr    <= w_clr_addr_nxt;
            r_row_ready   <= w_row_ready_nxt;
            r_overrun     <= w_overrun_nxt;
            r_overrun_cnt <= w_overrun_cnt_nxt;
        end
    end

    // Swap wins over everything: any in-flight prep is abandoned and restarted.
    always_comb begin
        w_state_nxt = r_state;
        if (w_swap) begin
            w_state_nxt = (w_nv < V_ACT) ? S_CLEAR : S_IDLE;
        end else begin
            case (r_state)
                S_CLEAR: if (w_clr_last) w_state_nxt = sprite_en ? S_START : S_DONE;
                S_START: w_state_nxt = S_GUARD;
                S_GUARD: w_state_nxt = S_WAIT;
                S_WAIT:  if (w_drained) w_state_nxt = S_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_start_row_nxt = (w_state_nxt == S_START);
        w_clr_we_nxt    = (w_state_nxt == S_CLEAR);
        w_clr_addr_nxt  = 10'd0;
        if (!w_swap && r_state == S_CLEAR && !w_clr_last)
            w_clr_addr_nxt = r_clr_addr + 10'd1;
        w_row_ready_nxt   = !w_swap && (r_state == S_DONE);
        w_overrun_nxt     = w_swap && (r_state != S_IDLE) && (r_state != S_DONE);
        w_overrun_cnt_nxt = r_overrun_cnt;
        if (w_overrun_nxt && r_overrun_cnt != 16'hFFFF)
            w_overrun_cnt_nxt = r_overrun_cnt + 16'd1;
    end

    assign start_row   = r_start_row;
    assign next_vcount = r_next_vcount;
    assign disp_sel    = r_disp_sel;
    assign clr_we      = r_clr_we;
    assign clr_addr    = r_clr_addr;
    assign row_ready   = r_row_ready;
    assign overrun     = r_overrun;
    assign overrun_cnt = r_overrun_cnt;

endmodule
